exc_arbiter: RTL

Exception arbiter: collects the per-instruction exception flags arriving at the MEM stage, recognises pending interrupts from the forwarded Status/Cause, and issues at most one prioritised exception code per instruction to cp0 (`except_type_cp0`, `delay_slot_cp0`, `pc_mempt2`, `mem_addr_ex`). It is registered: it forms the MEM/MEM-pt2 boundary for exception information. After each issued exception or ERET it blanks the pipeline flush window so flushed instructions never raise a second exception.

---
 rtl/exc_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/exc_arbiter.sv
// exc_arbiter: MEM-stage exception arbiter and MEM/MEM-pt2 exception register.
// Selects one prioritised exception code per captured instruction, registers it
// together with the instruction attributes, then locks out capture for
// FLUSH_CYCLES cycles so instructions being flushed cannot raise another code.
// Optional feature macro: EXC_ARB_INT_HOLD_EN (latch IP pulses until taken).

package exc_arbiter_pkg;
    // Encoded exception code handed to cp0; zero means no exception.
    typedef enum logic [3:0] {
        EXC_NONE      = 4'd0,
        EXC_INT       = 4'd1,
        EXC_WRPC      = 4'd2,
        EXC_INVALID   = 4'd3,
        EXC_OVFL      = 4'd4,
        EXC_SYS       = 4'd5,
        EXC_BREAK     = 4'd6,
        EXC_ERET      = 4'd7,
        EXC_WRADDR_LD = 4'd8,
        EXC_WRADDR_ST = 4'd9
    } except_bus_t;
endpackage

module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        stall,
    input  logic [31:0] in_pc,
    input  logic        in_delay_slot,
    input  logic [31:0] in_mem_addr,
    input  logic [7:0]  in_exc_flags,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    output except_bus_t except_type_cp0,
    output logic        delay_slot_cp0,
    output logic [31:0] pc_mempt2,
    output logic [31:0] mem_addr_ex
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    except_bus_t exc_q, exc_d;
    logic        ds_q, ds_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;

    logic [7:0]  ip_req;
    logic        int_ok;
    logic        int_take;
    logic        cap;
    except_bus_t code;
    logic [31:0] addr_sel;

    // Flag vector fields, bit 7..0 = {eret, ades, adel_ld, brk, sys, ov, ri, adel_if}
    logic f_eret, f_ades, f_adel_ld, f_brk, f_sys, f_ov, f_ri, f_adel_if;
    assign {f_eret, f_ades, f_adel_ld, f_brk, f_sys, f_ov, f_ri, f_adel_if} = in_exc_flags;

    // Status/Cause bits outside IE, EXL, IM and IP play no part here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

`ifdef EXC_ARB_INT_HOLD_EN
    logic [7:0] int_pend_q, int_pend_d;

    // Pending-IP accumulator: every IP pulse sticks until an interrupt is issued.
    always_comb begin
        int_pend_d = int_pend_q | cp0_cause[15:8];
        if (cap && (code == EXC_INT)) begin
            int_pend_d = 8'h00;
        end
    end

    // Pending-IP register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_pend_q <= 8'h00;
        end else begin
            int_pend_q <= int_pend_d;
        end
    end

    assign ip_req = cp0_cause[15:8] | int_pend_q;
`else
    assign ip_req = cp0_cause[15:8];
`endif

    // Interrupt recognition and fixed-priority code selection for the MEM instruction.
    always_comb begin
        int_ok   = cp0_status[0] & ~cp0_status[1];
        int_take = int_ok & (|(ip_req & cp0_status[15:8]));
        cap      = in_valid & ~stall & (state_q == ST_RUN);

        code = EXC_NONE;
        if (int_take)       code = EXC_INT;
        else if (f_adel_if) code = EXC_WRPC;
        else if (f_ri)      code = EXC_INVALID;
        else if (f_ov)      code = EXC_OVFL;
        else if (f_sys)     code = EXC_SYS;
        else if (f_brk)     code = EXC_BREAK;
        else if (f_eret)    code = EXC_ERET;
        else if (f_adel_ld) code = EXC_WRADDR_LD;
        else if (f_ades)    code = EXC_WRADDR_ST;

        // A fetch address error reports the faulting PC as the bad address.
        addr_sel = (code == EXC_WRPC) ? in_pc : in_mem_addr;
    end

    // RUN/LOCK next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exc_d   = EXC_NONE;
        ds_d    = ds_q;
        pc_d    = pc_q;
        addr_d  = addr_q;

        case (state_q)
            ST_RUN: begin
                if (cap) begin
                    exc_d  = code;
                    ds_d   = in_delay_slot;
                    pc_d   = in_pc;
                    addr_d = addr_sel;
                    if (code != EXC_NONE) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // Counts down unconditionally; the last lock cycle hands back to RUN.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and MEM-pt2 exception registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            exc_q   <= EXC_NONE;
            ds_q    <= 1'b0;
            pc_q    <= 32'h0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            ds_q    <= ds_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign except_type_cp0 = exc_q;
    assign delay_slot_cp0  = ds_q;
    assign pc_mempt2       = pc_q;
    assign mem_addr_ex     = addr_q;

endmodule
